// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with one-cycle pmem latency, skid buffer and redirect/flush squash
module fetch_unit #(
  parameter int PC_WIDTH        = 12,
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int PC_INCREMENT    = 2,
  parameter int RESET_PC        = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_set_pc,
  input  logic [PMEM_ADDR_WIDTH-1:0] in_branch_pc,
  input  logic                       in_flush,
  input  logic                       in_stall,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_rd_word,
  output logic                       out_pmem_rd_en,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_rd_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_valid
);
  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, infl_pc_q, skid_pc_q, skid_pc_d, out_pc_q, out_pc_d;
  logic [PMEM_WORD_WIDTH-1:0] skid_word_q, skid_word_d, out_instr_q, out_instr_d;
  logic infl_v_q, skid_v_q, skid_v_d, out_v_q, out_v_d;
  logic kill;
  // redirect/flush are ignored during BOOT
  assign kill = (in_set_pc || in_flush) && state_q != BOOT;
  assign out_pmem_rd_en = state_q == RUN && !in_stall && !kill;
  assign out_pmem_rd_addr = fetch_pc_q[PMEM_ADDR_WIDTH-1:0];
  assign out_instr = out_instr_q;
  assign out_pc = out_pc_q;
  assign out_valid = out_v_q;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    skid_v_d = skid_v_q;
    skid_word_d = skid_word_q;
    skid_pc_d = skid_pc_q;
    out_v_d = out_v_q;
    out_instr_d = out_instr_q;
    out_pc_d = out_pc_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (kill) begin
      state_d = RUN;
      skid_v_d = 1'b0;
      out_v_d = 1'b0;
      fetch_pc_d = in_set_pc ? PC_WIDTH'(in_branch_pc) : fetch_pc_q;
    end else if (state_q == STALL) begin
      if (!in_stall) begin
        state_d = RUN;
        skid_v_d = 1'b0;
        out_v_d = skid_v_q;
        out_instr_d = skid_word_q;
        out_pc_d = skid_pc_q;
      end
    end else if (!in_stall) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_INCREMENT);
      out_v_d = infl_v_q;
      out_instr_d = infl_v_q ? in_pmem_rd_word : out_instr_q;
      out_pc_d = infl_v_q ? infl_pc_q : out_pc_q;
    end else if (infl_v_q && !out_v_q) begin
      out_v_d = 1'b1;
      out_instr_d = in_pmem_rd_word;
      out_pc_d = infl_pc_q;
    end else if (infl_v_q) begin
      state_d = STALL;
      skid_v_d = 1'b1;
      skid_word_d = in_pmem_rd_word;
      skid_pc_d = infl_pc_q;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      fetch_pc_q <= PC_WIDTH'(RESET_PC);
      infl_v_q <= 1'b0;
      infl_pc_q <= '0;
      skid_v_q <= 1'b0;
      skid_word_q <= '0;
      skid_pc_q <= '0;
      out_v_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      infl_v_q <= out_pmem_rd_en;
      infl_pc_q <= fetch_pc_q;
      skid_v_q <= skid_v_d;
      skid_word_q <= skid_word_d;
      skid_pc_q <= skid_pc_d;
      out_v_q <= out_v_d;
      out_instr_q <= out_instr_d;
      out_pc_q <= out_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an in-order instruction-stream model checked every cycle
module tb_fetch_unit;
  logic clock, reset, in_set_pc, in_flush, in_stall;
  logic [11:0] in_branch_pc, out_pmem_rd_addr, out_pc;
  logic [15:0] in_pmem_rd_word, out_instr;
  logic out_pmem_rd_en, out_valid;
  int checks = 0, errors = 0, cyc = 0, quiet = 0;
  logic [11:0] exp_pc, resume_pc, prev_pc;
  logic [15:0] prev_instr;
  logic hold;

  fetch_unit dut (
    .clock(clock), .reset(reset), .in_set_pc(in_set_pc), .in_branch_pc(in_branch_pc),
    .in_flush(in_flush), .in_stall(in_stall), .in_pmem_rd_word(in_pmem_rd_word),
    .out_pmem_rd_en(out_pmem_rd_en), .out_pmem_rd_addr(out_pmem_rd_addr),
    .out_instr(out_instr), .out_pc(out_pc), .out_valid(out_valid)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic logic [15:0] word_at(logic [11:0] a);
    return 16'h1000 + 16'(a >> 1);
  endfunction

  always @(posedge clock) if (out_pmem_rd_en) in_pmem_rd_word <= word_at(out_pmem_rd_addr);

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Stream model: every newly presented instruction must be the next PC of the current path
  always @(negedge clock) begin
    if (reset) begin
      exp_pc = 12'h000;
      hold = 0;
      quiet = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pc", out_pc, prev_pc);
        chk("hold_instr", out_instr, prev_instr);
      end
      if (quiet > 0) begin
        chk("squash_quiet", out_valid, 0);
        quiet--;
      end
      if (out_valid) begin
        chk("instr_matches_pc", out_instr, word_at(out_pc));
        if (!hold) begin
          chk("stream_pc", out_pc, exp_pc);
          exp_pc = exp_pc + 12'd2;
        end
      end
      hold = out_valid && in_stall && !in_set_pc && !in_flush;
      prev_pc = out_pc;
      prev_instr = out_instr;
      if (in_set_pc) begin
        exp_pc = in_branch_pc;
        quiet = 2;
      end else if (in_flush) begin
        exp_pc = resume_pc;
        quiet = 2;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_to(int n);
    while (cyc < n) tick();
  endtask

  task automatic expect_out(string name, logic v, logic [11:0] pc);
    chk({name, "_valid"}, out_valid, v);
    if (v) begin
      chk({name, "_pc"}, out_pc, pc);
      chk({name, "_instr"}, out_instr, word_at(pc));
    end
  endtask

  initial begin
    reset = 1; in_set_pc = 0; in_flush = 0; in_stall = 0; in_branch_pc = 0; resume_pc = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_rden", out_pmem_rd_en, 0);
    reset = 0;
    cyc = 0;
    chk("boot_rden", out_pmem_rd_en, 0);
    chk("boot_addr", out_pmem_rd_addr, 12'h000);
    tick();
    chk("c1_rden", out_pmem_rd_en, 1);
    chk("c1_addr", out_pmem_rd_addr, 12'h000);
    tick();
    expect_out("c2", 0, 0);
    tick();
    expect_out("c3", 1, 12'h000);
    chk("c3_instr_lit", out_instr, 16'h1000);
    tick();
    expect_out("c4", 1, 12'h002);
    wait_to(11);
    expect_out("pre_stall", 1, 12'h010);
    in_stall = 1;
    repeat (4) begin
      expect_out("stall_hold", 1, 12'h010);
      tick();
    end
    in_stall = 0;
    expect_out("release", 1, 12'h010);
    tick();
    expect_out("skid", 1, 12'h012);
    tick();
    expect_out("bubble", 0, 0);
    tick();
    expect_out("resume0", 1, 12'h014);
    tick();
    expect_out("resume1", 1, 12'h016);
    wait_to(22);
    resume_pc = 12'h020;
    in_flush = 1;
    tick();
    in_flush = 0;
    expect_out("flush_q1", 0, 0);
    tick();
    expect_out("flush_q2", 0, 0);
    tick();
    expect_out("flush_resume", 1, 12'h020);
    wait_to(27);
    in_branch_pc = 12'h100;
    in_set_pc = 1;
    tick();
    in_set_pc = 0;
    expect_out("redir_q1", 0, 0);
    tick();
    expect_out("redir_q2", 0, 0);
    tick();
    expect_out("redir_t3", 1, 12'h100);
    tick();
    expect_out("redir_t4", 1, 12'h102);
    wait_to(32);
    expect_out("pre_stall2", 1, 12'h104);
    in_stall = 1;
    tick();
    tick();
    expect_out("stall2_hold", 1, 12'h104);
    in_branch_pc = 12'h040;
    in_set_pc = 1;
    tick();
    in_set_pc = 0;
    in_stall = 0;
    expect_out("sredir_q1", 0, 0);
    tick();
    expect_out("sredir_q2", 0, 0);
    tick();
    expect_out("sredir_t3", 1, 12'h040);
    tick();
    expect_out("sredir_t4", 1, 12'h042);
    wait_to(39);
    in_branch_pc = 12'hFFC;
    in_set_pc = 1;
    tick();
    in_set_pc = 0;
    wait_to(42);
    expect_out("wrap0", 1, 12'hFFC);
    tick();
    expect_out("wrap1", 1, 12'hFFE);
    tick();
    expect_out("wrap2", 1, 12'h000);
    chk("wrap2_instr_lit", out_instr, 16'h1000);
    tick();
    expect_out("wrap3", 1, 12'h002);
    reset = 1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_pc", out_pc, 0);
    chk("async_instr", out_instr, 0);
    chk("async_rden", out_pmem_rd_en, 0);
    @(posedge clock);
    #1;
    reset = 0;
    cyc = 0;
    chk("reboot_rden", out_pmem_rd_en, 0);
    tick();
    tick();
    expect_out("reboot_c2", 0, 0);
    tick();
    expect_out("reboot_c3", 1, 12'h000);
    tick();
    expect_out("reboot_c4", 1, 12'h002);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
